// File: rtl/std_mem_arbiter_pkg.sv
// Shared constants and the round-robin pick helper for the std_mem command arbiter.
package std_mem_arbiter_pkg;

  localparam int unsigned PORTS_DEF      = 4;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 10;
  localparam int unsigned TAG_DEPTH_DEF  = 4;
  localparam int unsigned TAG_WIDTH      = $clog2(PORTS_DEF);
  localparam int unsigned MAX_PORTS      = 32;

  // First set bit of mask searching from last+1 upward, wrapping at ports; returns last if none.
  function automatic int rr_pick(input logic [MAX_PORTS-1:0] mask, input int last, input int ports);
    int idx;
    rr_pick = last;
    for (int k = MAX_PORTS; k >= 1; k--) begin
      if (k <= ports) begin
        idx = (last + k) % ports;
        if (mask[idx]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/std_tag_fifo.sv
// Circular FIFO of requester tags for outstanding reads; head is the next result's owner.
module std_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_tag_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = slot_q[rd_ptr_q];
  // Push is refused when full even if a pop lands in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) slot_q[wr_ptr_q] <= push_tag_i;
  end

endmodule

// File: rtl/std_mem_arbiter.sv
// Round-robin sharing of one single-cycle std_mem port; read results steered back in order by tag.
module std_mem_arbiter
  import std_mem_arbiter_pkg::*;
#(
  parameter int unsigned PORTS      = PORTS_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned TAG_DEPTH  = TAG_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS-1:0]              req_valid,
  output logic [PORTS-1:0]              req_ready,
  input  logic [PORTS-1:0]              req_read_enable,
  input  logic [PORTS*MASK_WIDTH-1:0]   req_write_enable,
  input  logic [PORTS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [PORTS*DATA_WIDTH-1:0]   req_data,
  output logic [PORTS-1:0]              rsp_valid,
  input  logic [PORTS-1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          mem_cmd_valid,
  input  logic                          mem_cmd_ready,
  output logic                          mem_cmd_read_enable,
  output logic [MASK_WIDTH-1:0]         mem_cmd_write_enable,
  output logic [ADDR_WIDTH-1:0]         mem_cmd_addr,
  output logic [DATA_WIDTH-1:0]         mem_cmd_data,
  input  logic                          mem_rsp_valid,
  output logic                          mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0]         mem_rsp_data
);

  localparam int unsigned TAG_W = $clog2(PORTS);

  logic [PORTS-1:0] eligible;
  logic [TAG_W-1:0] grant;
  logic [TAG_W-1:0] last_grant_q, last_grant_d;
  logic [TAG_W-1:0] held_q, held_d;
  logic             lock_q, lock_d;
  logic             tag_full, tag_empty;
  logic [TAG_W-1:0] tag_head;
  logic             cmd_fire, tag_push, tag_pop;

  // Reads are masked out while every tag is in flight; writes always compete.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      eligible[i] = req_valid[i] && (!req_read_enable[i] || !tag_full);
    end
  end

  assign grant = lock_q ? held_q
                        : TAG_W'(rr_pick(MAX_PORTS'(eligible), int'(last_grant_q), int'(PORTS)));
  assign mem_cmd_valid = !rst && (lock_q || (|eligible));
  assign cmd_fire      = mem_cmd_valid && mem_cmd_ready;
  assign tag_push      = cmd_fire && mem_cmd_read_enable;

  always_comb begin
    mem_cmd_read_enable  = 1'b0;
    mem_cmd_write_enable = '0;
    mem_cmd_addr         = '0;
    mem_cmd_data         = '0;
    req_ready            = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (grant == TAG_W'(i)) begin
        mem_cmd_read_enable  = req_read_enable[i];
        mem_cmd_write_enable = req_write_enable[i*MASK_WIDTH +: MASK_WIDTH];
        mem_cmd_addr         = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_cmd_data         = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i]         = cmd_fire;
      end
    end
  end

  // A stalled command pins the grant so its fields stay stable until accepted.
  always_comb begin
    last_grant_d = last_grant_q;
    held_d       = held_q;
    lock_d       = lock_q;
    if (cmd_fire) begin
      last_grant_d = grant;
      lock_d       = 1'b0;
    end else if (mem_cmd_valid) begin
      held_d = grant;
      lock_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= TAG_W'(PORTS - 1);
      held_q       <= '0;
      lock_q       <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      held_q       <= held_d;
      lock_q       <= lock_d;
    end
  end

  std_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (tag_push),
    .push_tag_i (grant),
    .pop_i      (tag_pop),
    .full_o     (tag_full),
    .empty_o    (tag_empty),
    .head_o     (tag_head)
  );

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      rsp_valid[i] = !rst && mem_rsp_valid && !tag_empty && (tag_head == TAG_W'(i));
    end
  end

  assign rsp_data      = mem_rsp_data;
  assign mem_rsp_ready = !rst && !tag_empty && rsp_ready[tag_head];
  assign tag_pop       = mem_rsp_valid && mem_rsp_ready;

  a_rsp_has_tag: assert property (@(posedge clk) disable iff (rst) mem_rsp_valid |-> !tag_empty);

endmodule

// File: tb/tb_std_mem_arbiter.sv
// Randomized and directed bench for std_mem_arbiter against a queue-based behavioural model.
module tb_std_mem_arbiter;

  localparam int P  = 4;
  localparam int D  = 32;
  localparam int A  = 10;
  localparam int M  = 4;
  localparam int TD = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [P-1:0]     req_valid = '0, req_ready, req_read_enable = '0;
  logic [P*M-1:0]   req_write_enable = '0;
  logic [P*A-1:0]   req_addr = '0;
  logic [P*D-1:0]   req_data = '0;
  logic [P-1:0]     rsp_valid, rsp_ready = '0;
  logic [D-1:0]     rsp_data;
  logic             mem_cmd_valid, mem_cmd_ready = 1'b0, mem_cmd_read_enable;
  logic [M-1:0]     mem_cmd_write_enable;
  logic [A-1:0]     mem_cmd_addr;
  logic [D-1:0]     mem_cmd_data;
  logic             mem_rsp_valid = 1'b0, mem_rsp_ready;
  logic [D-1:0]     mem_rsp_data = '0;

  std_mem_arbiter #(
    .PORTS(P), .DATA_WIDTH(D), .ADDR_WIDTH(A), .MASK_WIDTH(M), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_read_enable(req_read_enable),
    .req_write_enable(req_write_enable), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_read_enable(mem_cmd_read_enable), .mem_cmd_write_enable(mem_cmd_write_enable),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_data(mem_cmd_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side pending commands (held until accepted)
  bit           pend [P];
  bit           p_rd [P];
  logic [M-1:0] p_we [P];
  logic [A-1:0] p_addr [P];
  logic [D-1:0] p_data [P];

  // Memory and model state
  logic [D-1:0] mem [1<<A];
  int           tagq [$];
  logic [D-1:0] memq [$];
  logic [D-1:0] expq [P][$];
  int           last_g = P - 1;
  bit           locked = 1'b0;
  int           held   = 0;
  int           waitc [P];

  // Knobs
  int           p_new = 0, rd_pct = 50, cmd_pct = 100, rsp_pct = 100;
  logic [P-1:0] gen_mask = '0, rsp_mask = '1;
  bit           rst_next = 1'b1;

  // DUT-observed activity
  int glog [$];
  int gcount [P];
  int obs_rd = 0, obs_wr = 0, obs_rsp = 0;

  task automatic set_cmd(input int i, input bit rd, input logic [A-1:0] addr);
    pend[i]   = 1'b1;
    p_rd[i]   = rd;
    p_we[i]   = rd ? '0 : M'($urandom_range(1, (1 << M) - 1));
    p_addr[i] = addr;
    p_data[i] = $urandom;
  endtask

  task automatic drive();
    rst = rst_next;
    for (int i = 0; i < P; i++) begin
      if (!pend[i] && gen_mask[i] && int'($urandom_range(99)) < p_new)
        set_cmd(i, int'($urandom_range(99)) < rd_pct, A'($urandom_range(0, 31)));
      req_valid[i]             = pend[i];
      req_read_enable[i]       = pend[i] && p_rd[i];
      req_write_enable[i*M+:M] = pend[i] ? p_we[i] : '0;
      req_addr[i*A+:A]         = p_addr[i];
      req_data[i*D+:D]         = p_data[i];
      rsp_ready[i]             = rsp_mask[i] && (int'($urandom_range(99)) < rsp_pct);
    end
    mem_cmd_ready = int'($urandom_range(99)) < cmd_pct;
    mem_rsp_valid = memq.size() > 0;
    mem_rsp_data  = (memq.size() > 0) ? memq[0] : D'($urandom);
  endtask

  task automatic evaluate();
    logic [P-1:0] cand, exp_rr, exp_rv;
    bit           any, exp_mrr, fire, dut_fire;
    int           g, head, dut_g;
    dut_fire = mem_cmd_valid && mem_cmd_ready;
    dut_g    = -1;
    if (dut_fire) begin
      for (int i = 0; i < P; i++) if (req_ready[i]) dut_g = i;
      glog.push_back(dut_g);
      if (dut_g >= 0) gcount[dut_g]++;
      if (mem_cmd_read_enable) obs_rd++; else obs_wr++;
    end
    for (int i = 0; i < P; i++) if (rsp_valid[i] && rsp_ready[i]) obs_rsp++;

    if (rst) begin
      check_eq("rst_outputs", 64'({req_ready, rsp_valid, mem_cmd_valid, mem_rsp_ready}), 64'(0));
      tagq.delete();
      memq.delete();
      for (int i = 0; i < P; i++) begin expq[i].delete(); waitc[i] = 0; end
      locked = 1'b0;
      last_g = P - 1;
      return;
    end

    for (int i = 0; i < P; i++) cand[i] = pend[i] && (!p_rd[i] || tagq.size() < TD);
    any = 1'b0;
    g   = 0;
    if (locked) begin
      any = 1'b1;
      g   = held;
    end else begin
      for (int k = 1; k <= P; k++) begin
        if (!any && cand[(last_g + k) % P]) begin any = 1'b1; g = (last_g + k) % P; end
      end
    end
    check_eq("cmd_valid", 64'(mem_cmd_valid), 64'(any));
    exp_rr = (any && mem_cmd_ready) ? (P'(1) << g) : '0;
    check_eq("req_ready", 64'(req_ready), 64'(exp_rr));
    if (any) begin
      check_eq("cmd_fields", 64'({mem_cmd_read_enable, mem_cmd_write_enable, mem_cmd_addr}),
               64'({p_rd[g], p_we[g], p_addr[g]}));
      check_eq("cmd_data", 64'(mem_cmd_data), 64'(p_data[g]));
    end

    head    = (tagq.size() > 0) ? tagq[0] : -1;
    exp_rv  = (mem_rsp_valid && head >= 0) ? (P'(1) << head) : '0;
    exp_mrr = (head >= 0) && rsp_ready[head];
    check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    check_eq("mem_rsp_ready", 64'(mem_rsp_ready), 64'(exp_mrr));
    if (mem_rsp_valid && exp_mrr)
      check_eq("rsp_data", 64'(rsp_data), 64'(expq[head][0]));

    // Fairness measured on the DUT's actual grants
    for (int i = 0; i < P; i++) begin
      if (dut_fire && dut_g == i) begin
        check_eq("rr_wait_bound", 64'(waitc[i] < P), 64'(1));
        waitc[i] = 0;
      end else if (!cand[i]) begin
        waitc[i] = 0;
      end else if (dut_fire) begin
        waitc[i]++;
      end
    end

    fire = any && mem_cmd_ready;
    if (mem_rsp_valid && exp_mrr) begin
      void'(tagq.pop_front());
      void'(memq.pop_front());
      void'(expq[head].pop_front());
    end
    if (fire) begin
      if (p_rd[g]) begin
        tagq.push_back(g);
        expq[g].push_back(mem[p_addr[g]]);
        memq.push_back(mem[p_addr[g]]);
      end
      for (int b = 0; b < M; b++) if (p_we[g][b]) mem[p_addr[g]][b*8 +: 8] = p_data[g][b*8 +: 8];
      pend[g] = 1'b0;
      last_g  = g;
      locked  = 1'b0;
    end else if (any) begin
      locked = 1'b1;
      held   = g;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    evaluate();
  endtask

  initial begin
    int r0;
    for (int k = 0; k < (1 << A); k++) mem[k] = $urandom;
    for (int i = 0; i < P; i++) begin pend[i] = 1'b0; waitc[i] = 0; gcount[i] = 0; end
    repeat (3) step();
    rst_next = 1'b0;
    step();

    // Back-to-back reads from every port: grant order 0,1,2,3
    for (int i = 0; i < P; i++) set_cmd(i, 1'b1, A'('h10 + i));
    glog.delete();
    repeat (8) step();
    check_eq("t1_count", 64'(glog.size()), 64'(4));
    for (int k = 0; k < glog.size() && k < 4; k++) check_eq("t1_order", 64'(glog[k]), 64'(k));

    // Stalled command holds its grant while a higher-priority port waits
    glog.delete();
    set_cmd(1, 1'b1, A'('h20));
    cmd_pct = 0;
    step();
    set_cmd(0, 1'b1, A'('h21));
    repeat (2) step();
    cmd_pct = 100;
    repeat (4) step();
    check_eq("t2_count", 64'(glog.size()), 64'(2));
    if (glog.size() == 2) begin
      check_eq("t2_first", 64'(glog[0]), 64'(1));
      check_eq("t2_second", 64'(glog[1]), 64'(0));
    end

    // Tag exhaustion: reads stall at TAG_DEPTH, a write still goes through
    rsp_mask = '0; gen_mask = 4'b1011; p_new = 100; rd_pct = 100;
    set_cmd(2, 1'b0, A'('h05));
    obs_rd = 0; obs_wr = 0;
    repeat (8) step();
    check_eq("t3_reads_full", 64'(obs_rd), 64'(TD));
    check_eq("t3_write", 64'(obs_wr), 64'(1));
    rsp_mask = (tagq.size() > 0) ? (P'(1) << tagq[0]) : '0;
    step();
    rsp_mask = '0;
    repeat (3) step();
    check_eq("t3_read_after_pop", 64'(obs_rd), 64'(TD + 1));

    // In-order delivery: head owner not ready blocks everyone behind it
    r0 = obs_rsp;
    rsp_mask = (tagq.size() > 0) ? ~(P'(1) << tagq[0]) : '0;
    repeat (3) step();
    check_eq("t4_inorder_hold", 64'(obs_rsp), 64'(r0));

    // Reset with reads outstanding, then port 0 wins first
    rst_next = 1'b1;
    step();
    rst_next = 1'b0;
    gen_mask = '0;
    rsp_mask = '1;
    for (int i = 0; i < P; i++) set_cmd(i, 1'b1, A'('h30 + i));
    glog.delete();
    repeat (6) step();
    check_eq("t5_first_grant", 64'((glog.size() > 0) ? glog[0] : -1), 64'(0));

    // Saturating writes: equal share over 40 handshakes
    repeat (8) step();
    for (int i = 0; i < P; i++) gcount[i] = 0;
    gen_mask = '1; rd_pct = 0; p_new = 100; cmd_pct = 100;
    repeat (40) step();
    gen_mask = '0;
    for (int i = 0; i < P; i++) check_eq("t6_share", 64'(gcount[i]), 64'(10));
    repeat (8) step();

    // Randomized traffic
    obs_rd = 0; obs_rsp = 0;
    gen_mask = '1; rsp_mask = '1;
    for (int blk = 0; blk < 15; blk++) begin
      p_new   = $urandom_range(20, 100);
      rd_pct  = $urandom_range(30, 90);
      cmd_pct = $urandom_range(30, 100);
      rsp_pct = $urandom_range(10, 100);
      repeat (200) step();
    end
    gen_mask = '0; cmd_pct = 100; rsp_pct = 100;
    repeat (30) step();
    check_eq("drain_balance", 64'(obs_rsp), 64'(obs_rd));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
